hilo_acc_unit: RTL and testbench
================================

Name: hilo_acc_unit

Overview:
- Parameterised HI/LO register pair for the MIPS pipeline.
- Supports independent HI-only and LO-only writes (MTHI/MTLO) and full writes (MULT/DIV results).
- Adds a two-cycle multiply-accumulate path (MADD/MSUB) with busy handshake and flush.
- Provides write-through forwarding outputs to MFHI/MFLO.
- Sits at the WB boundary beside the register file; fed by the EX/MEM multiplier result and the exception/flush logic.

Parameters:
- DATA_W, 32, width of each of HI and LO; product width is 2*DATA_W.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_hi  in  1  write hi_i into HI.
- wr_lo  in  1  write lo_i into LO.
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- acc_valid  in  1  accumulate request (MADD/MSUB family).
- acc_sub  in  1  0 = HI:LO + prod_i, 1 = HI:LO - prod_i.
- prod_i  in  2*DATA_W  product; already sign- or zero-extended upstream.
- flush  in  1  cancel pending accumulate (exception/branch flush).
- hi_o  out  DATA_W  committed HI.
- lo_o  out  DATA_W  committed LO.
- hi_fwd  out  DATA_W  forwarded HI, combinational.
- lo_fwd  out  DATA_W  forwarded LO, combinational.
- busy  out  1  accumulate in flight; upstream must stall HI/LO ops.

Behaviour:
- Reset:
  - hi_o = 0, lo_o = 0, busy = 0.
  - Stage-1 registers (prod_q, sub_q) cleared.
  - Reset overrides every other input, including mid-accumulate.
- Direct write (busy = 0, acc_valid = 0):
  - wr_hi updates HI and wr_lo updates LO at the next edge, 1-cycle latency.
  - The two enables are independent; an unselected half holds its value.
- Accumulate, two cycles:
  - Cycle N, acc_valid = 1 and busy = 0: latch prod_i and acc_sub into stage 1; busy = 1 from cycle N+1.
  - Cycle N+1, busy = 1 and no flush: {HI,LO} <= {HI,LO} +/- prod_q, computed modulo 2^(2*DATA_W) with no overflow trap. The carry/borrow from LO propagates into HI. busy = 0 from cycle N+2.
- Result is visible on hi_o/lo_o in cycle N+2.
- State machine:
  - IDLE: busy = 0. acc_valid moves to ACC.
  - ACC: busy = 1. Always returns to IDLE next cycle. flush returns to IDLE with no commit.
- Priority, highest first: rst, flush, ACC commit, acc_valid, wr_hi/wr_lo.
- Simultaneous events:
  - acc_valid with wr_hi or wr_lo in IDLE: acc_valid wins and the writes are dropped. Upstream never issues both; the bench checks the drop.
  - Any request (acc_valid, wr_*) while busy = 1 is ignored; upstream holds it until busy = 0.
  - flush in IDLE: no effect on HI/LO; the same-cycle wr_* and acc_valid are also dropped.
  - flush in ACC: HI/LO unchanged, busy = 0 next cycle.
- Forwarding:
  - hi_fwd = hi_i when (wr_hi & ~busy & ~acc_valid & ~flush), else hi_o.
  - lo_fwd uses the same rule with wr_lo, lo_i and lo_o.
  - There is no forwarding of the accumulate result; consumers stall on busy.

Decomposition:
- Shared defines header gains:
  - HILO_ACC_ADD / HILO_ACC_SUB encodings.
  - Existing RstEnable, WriteEnable and ZeroWord macros, reused.
  - DATA_W default tied to the existing RegBus width.
- One natural sub-module, hilo_acc_adder:
  - Combinational 2*DATA_W add/subtract, implemented as invert-plus-carry-in.
  - Kept separate so a pipelined adder can be substituted for wide DATA_W.

Test Plan:
- Reset, then wr_hi = 1 with hi_i = 0x1234_5678, wr_lo = 0 → next cycle hi_o = 0x1234_5678, lo_o = 0; hi_fwd equals hi_i during the write cycle.
- HI:LO = 0x0000_0000:FFFF_FFFF; acc_valid with acc_sub = 0, prod_i = 1 → busy = 1 for one cycle, then hi_o = 0x0000_0001, lo_o = 0 (carry across halves).
- HI:LO = 0:0; acc_sub = 1, prod_i = 1 → HI:LO = 0xFFFF_FFFF:FFFF_FFFF (wrap, no trap).
- Accumulate accepted, flush asserted in the ACC cycle → HI:LO unchanged and busy = 0 next cycle. A wr_lo issued during busy is ignored.
- acc_valid together with wr_hi (hi_i = 0xDEAD_BEEF) from HI:LO = 2:3, prod_i = 5 → HI:LO = 2:8; the 0xDEAD_BEEF write is dropped.
- Reset asserted while busy = 1 → next cycle hi_o = lo_o = 0 and busy = 0; no late commit.

Source files
------------

// File: rtl/hilo_acc_pkg.sv
// Shared constants for the HI/LO accumulate unit: operation encodings,
// enable/zero values and the register-bus width used as the default data width.
package hilo_acc_pkg;

    localparam int REG_BUS_W = 32;

    localparam logic HILO_ACC_ADD = 1'b0;
    localparam logic HILO_ACC_SUB = 1'b1;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/hilo_acc_unit_adder.sv
// Combinational wide add/subtract for the HI:LO accumulate path.
// Subtraction is done as a + ~b + 1 so one adder serves both operations.
// Isolated so a pipelined adder can replace it for wide data paths.
module hilo_acc_unit_adder
    import hilo_acc_pkg::*;
#(
    parameter int WIDTH = 2 * REG_BUS_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin_ext;

    // Invert the second operand and inject the carry-in for subtraction.
    always_comb begin
        b_eff   = (sub_i == HILO_ACC_SUB) ? ~b_i : b_i;
        cin_ext = {{(WIDTH-1){1'b0}}, (sub_i == HILO_ACC_SUB)};
        sum_o   = a_i + b_eff + cin_ext;
    end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with independent MTHI/MTLO writes, a two-cycle
// multiply-accumulate path (MADD/MSUB) with busy handshake and flush,
// and write-through forwarding of direct writes to MFHI/MFLO.
module hilo_acc_unit
    import hilo_acc_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    input  logic                  acc_valid,
    input  logic                  acc_sub,
    input  logic [2*DATA_W-1:0]   prod_i,
    input  logic                  flush,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic [DATA_W-1:0]     hi_fwd,
    output logic [DATA_W-1:0]     lo_fwd,
    output logic                  busy
);

    hilo_state_e           state_q, state_d;
    logic                  busy_q, busy_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;
    logic                  sub_q, sub_d;
    logic [2*DATA_W-1:0]   acc_sum;
    logic                  direct_ok;

    hilo_acc_unit_adder #(
        .WIDTH (2 * DATA_W)
    ) u_adder (
        .a_i   ({hi_q, lo_q}),
        .b_i   (prod_q),
        .sub_i (sub_q),
        .sum_o (acc_sum)
    );

    // A direct write takes effect only when nothing of higher priority claims the cycle.
    assign direct_ok = ~busy_q & ~acc_valid & ~flush;

    // Next-state: flush beats the ACC commit, which beats a new request, which beats writes.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        sub_d   = sub_q;
        if (state_q == ST_ACC) begin
            state_d = ST_IDLE;
            if (!flush) begin
                {hi_d, lo_d} = acc_sum;
            end
        end else if (!flush) begin
            if (acc_valid) begin
                state_d = ST_ACC;
                prod_d  = prod_i;
                sub_d   = acc_sub;
            end else begin
                if (wr_hi == WRITE_ENABLE) hi_d = hi_i;
                if (wr_lo == WRITE_ENABLE) lo_d = lo_i;
            end
        end
        busy_d = (state_d == ST_ACC);
    end

    // State and datapath registers; reset overrides everything, including an in-flight accumulate.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            sub_q   <= HILO_ACC_ADD;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            sub_q   <= sub_d;
        end
    end

    // Forward same-cycle direct writes; accumulate results are never forwarded.
    always_comb begin
        hi_fwd = (wr_hi && direct_ok) ? hi_i : hi_q;
        lo_fwd = (wr_lo && direct_ok) ? lo_i : lo_q;
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Self-checking bench for hilo_acc_unit: directed test-plan steps followed by
// randomized traffic, all checked against a 64-bit arithmetic reference model.
module tb_hilo_acc_unit;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst, wr_hi, wr_lo, acc_valid, acc_sub, flush;
    logic [W-1:0]    hi_i, lo_i;
    logic [2*W-1:0]  prod_i;
    logic [W-1:0]    hi_o, lo_o, hi_fwd, lo_fwd;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Reference model: HI:LO as one 64-bit number plus a pending accumulate.
    logic [63:0] m_acc;
    logic        m_busy;
    logic [63:0] m_prod;
    logic        m_sub;

    always #5 clk = ~clk;

    hilo_acc_unit #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .hi_i      (hi_i),
        .lo_i      (lo_i),
        .acc_valid (acc_valid),
        .acc_sub   (acc_sub),
        .prod_i    (prod_i),
        .flush     (flush),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .hi_fwd    (hi_fwd),
        .lo_fwd    (lo_fwd),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock of stimulus: check forwarding mid-cycle, then committed state after the edge.
    task automatic do_cycle(input logic r, input logic wh, input logic wl,
                            input logic [31:0] hv, input logic [31:0] lv,
                            input logic av, input logic as_, input logic [63:0] p,
                            input logic fl);
        logic [31:0] e_hf, e_lf;
        rst = r; wr_hi = wh; wr_lo = wl; hi_i = hv; lo_i = lv;
        acc_valid = av; acc_sub = as_; prod_i = p; flush = fl;
        #1;
        e_hf = (wh && !m_busy && !av && !fl) ? hv : m_acc[63:32];
        e_lf = (wl && !m_busy && !av && !fl) ? lv : m_acc[31:0];
        if (!r) begin
            chk("hi_fwd", {32'd0, hi_fwd}, {32'd0, e_hf});
            chk("lo_fwd", {32'd0, lo_fwd}, {32'd0, e_lf});
        end
        if (r) begin
            m_acc = 64'd0; m_busy = 1'b0; m_prod = 64'd0; m_sub = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
            if (!fl) m_acc = m_sub ? (m_acc - m_prod) : (m_acc + m_prod);
        end else if (!fl) begin
            if (av) begin
                m_busy = 1'b1; m_prod = p; m_sub = as_;
            end else begin
                if (wh) m_acc[63:32] = hv;
                if (wl) m_acc[31:0]  = lv;
            end
        end
        @(posedge clk);
        #1;
        chk("hi_o", {32'd0, hi_o}, {32'd0, m_acc[63:32]});
        chk("lo_o", {32'd0, lo_o}, {32'd0, m_acc[31:0]});
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        $display("cycle rst=%0b wh=%0b wl=%0b av=%0b sub=%0b fl=%0b -> hi=%h lo=%h busy=%0b",
                 r, wh, wl, av, as_, fl, hi_o, lo_o, busy);
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0, 0);
    endtask

    initial begin
        rst = 1; wr_hi = 0; wr_lo = 0; hi_i = '0; lo_i = '0;
        acc_valid = 0; acc_sub = 0; prod_i = '0; flush = 0;
        m_acc = 64'd0; m_busy = 0; m_prod = 64'd0; m_sub = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // HI-only write with forwarding
        rst = 0; wr_hi = 1; hi_i = 32'h1234_5678; #1;
        chk("fwd_hi_write", {32'd0, hi_fwd}, 64'h1234_5678);
        do_cycle(0, 1, 0, 32'h1234_5678, 32'hAAAA_AAAA, 0, 0, 64'd0, 0);
        chk("mthi_hi", {32'd0, hi_o}, 64'h1234_5678);
        chk("mthi_lo", {32'd0, lo_o}, 64'd0);

        // Carry across halves
        do_cycle(0, 1, 1, 32'h0, 32'hFFFF_FFFF, 0, 0, 64'd0, 0);
        do_cycle(0, 0, 0, 32'd0, 32'd0, 1, 0, 64'd1, 0);
        chk("acc_busy", {63'd0, busy}, 64'd1);
        idle();
        chk("carry", {hi_o, lo_o}, 64'h0000_0001_0000_0000);

        // Subtract wrap
        do_cycle(0, 1, 1, 32'h0, 32'h0, 0, 0, 64'd0, 0);
        do_cycle(0, 0, 0, 32'd0, 32'd0, 1, 1, 64'd1, 0);
        idle();
        chk("wrap", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush in ACC, wr_lo during busy ignored
        do_cycle(0, 0, 0, 32'd0, 32'd0, 1, 0, 64'd7, 0);
        do_cycle(0, 0, 1, 32'd0, 32'h5555_5555, 0, 0, 64'd0, 1);
        chk("flush_keep", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_busy", {63'd0, busy}, 64'd0);

        // Write issued during busy is ignored
        do_cycle(0, 0, 0, 32'd0, 32'd0, 1, 0, 64'd2, 0);
        do_cycle(0, 0, 1, 32'd0, 32'h5555_5555, 0, 0, 64'd0, 0);
        chk("busy_wr_drop", {hi_o, lo_o}, 64'd1);

        // acc_valid beats wr_hi
        do_cycle(0, 1, 1, 32'd2, 32'd3, 0, 0, 64'd0, 0);
        do_cycle(0, 1, 0, 32'hDEAD_BEEF, 32'd0, 1, 0, 64'd5, 0);
        idle();
        chk("acc_wins", {hi_o, lo_o}, 64'h0000_0002_0000_0008);

        // Flush in IDLE drops writes
        do_cycle(0, 1, 1, 32'h1111_1111, 32'h2222_2222, 0, 0, 64'd0, 1);
        chk("idle_flush", {hi_o, lo_o}, 64'h0000_0002_0000_0008);

        // Reset mid-accumulate
        do_cycle(0, 0, 0, 32'd0, 32'd0, 1, 0, 64'd100, 0);
        do_cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0, 0);
        chk("rst_mid", {hi_o, lo_o}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        idle();
        chk("no_late_commit", {hi_o, lo_o}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 49) == 0),
                     $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom, $urandom,
                     ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                     {$urandom, $urandom},
                     ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
